i2c_config_sequencer: RTL and testbench
=======================================

I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- CLK_FREQ, 25000000, sys_clock frequency in Hz.
- DEV_ADDR, 8'h78, I2C write address of the sensor.
- TBL_AW, 8, table address width; table depth is 2**TBL_AW.
- PWRUP_MS, 20, delay after start before the first write.
- GAP_CYCLES, 64, go-low cycles between writes.
- TIMEOUT_CYCLES, 2**20, maximum wait per handshake phase.
REQ-002 Ports (name, direction, width, meaning):
- sys_clock, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- cfg_start, in, 1, rising edge begins a configuration pass.
- tbl_addr, out, TBL_AW, table read address.
- tbl_data, in, 24, table entry; valid one cycle after tbl_addr changes (registered ROM).
- I2C_addr, out, 8, device address to the controller.
- I2C_WDATA, out, 24, {reg_addr[15:0], data[7:0]} to the controller.
- go, out, 1, transfer request to the controller.
- trans_finished, in, 1, controller idle/finished flag.
- busy, out, 1, pass in progress.
- cfg_done, out, 1, pass completed; sticky.
- cfg_err, out, 1, timeout occurred; sticky.
- err_index, out, TBL_AW, table index at the timeout.

Function
REQ-003 One clock domain (sys_clock); synchronous active-high reset (rst); all outputs are registered.
REQ-004 States: IDLE, PWRUP, FETCH, DECODE, REQ, XFER, GAP, DELAY, DONE, ERR.
REQ-005 IDLE: a cfg_start rising edge (registered edge detect) clears cfg_done, cfg_err and the index, then enters PWRUP; cfg_start while busy=1 is ignored.
REQ-006 PWRUP: wait PWRUP_MS milliseconds, then enter FETCH; a millisecond is CLK_FREQ/1000 cycles, from a prescaler counter.
REQ-007 FETCH: drive tbl_addr=index; tbl_data is sampled exactly one cycle later, in DECODE.
REQ-008 DECODE on tbl_data[23:8]:
- 16'hFFFF: delay entry; enter DELAY for tbl_data[7:0] ms (0 means no delay).
- 16'hFFFE: end marker; enter DONE.
- any other value: latch I2C_WDATA=tbl_data and I2C_addr=DEV_ADDR, then enter REQ.
REQ-009 REQ: assert go; wait for trans_finished=0 (transfer accepted), then enter XFER; go stays high for the whole transfer, because the controller aborts when go is low.
REQ-010 XFER: wait for trans_finished=1, then deassert go and enter GAP.
REQ-011 I2C_WDATA and I2C_addr SHALL stay stable from REQ entry until GAP exit.
REQ-012 GAP: hold go=0 for GAP_CYCLES; then, if index is the last table entry (2**TBL_AW-1), enter DONE; otherwise increment the index and enter FETCH.
REQ-013 DELAY exit: increment the index and enter FETCH, unless the index is the last entry, in which case enter DONE.
REQ-014 Timeout: a per-phase counter SHALL run in REQ and in XFER and be cleared on each phase entry. Reaching TIMEOUT_CYCLES enters ERR, deasserts go, sets cfg_err=1 and err_index=index.
REQ-015 DONE: set cfg_done=1, then enter IDLE. ERR: enter IDLE.
REQ-016 Outputs: busy=1 in every state except IDLE; go=1 only in REQ and XFER.
REQ-017 trans_finished is double-flop synchronised before use; all handshake timing counts from the synchronised value.
REQ-018 Each entry's data reaches I2C_WDATA exactly once per pass; there are no retries.

Reset
REQ-019 rst=1 forces, at the next sys_clock edge:
- state=IDLE, go=0, busy=0, cfg_done=0, cfg_err=0;
- err_index=0, tbl_addr=0, I2C_WDATA=0, I2C_addr=DEV_ADDR;
- all counters=0, edge-detect register=0.
REQ-020 rst asserted mid-transfer drops go in the same cycle; the next pass starts only on a new cfg_start edge.

Structure
REQ-021 The state encoding, the 16'hFFFF/16'hFFFE markers and the ms-prescaler formula SHALL be defined in a shared package, i2c_cfg_pkg.
REQ-022 One sub-module, cfg_delay_timer (ms prescaler plus 8-bit ms down-counter with load/expired), serves both PWRUP and DELAY.
REQ-023 The configuration table is external to this block (register ROM); this block contains no table contents.

Verification
REQ-024 Each scenario runs with a behavioural controller model: trans_finished drops 3 cycles after go rises and returns high 100 cycles later.
- Table {3008_82, 3103_03, FFFE_00}, cfg_start pulse -> go held low for 20 ms; then two transfers with I2C_WDATA=24'h300882 then 24'h310303; cfg_done=1; busy=0.
- Table {FFFF_05, 4300_30, FFFE_00} -> at least 5*25000 cycles between PWRUP end and the first go; one transfer with 24'h430030.
- Model never drops trans_finished -> cfg_err=1 after TIMEOUT_CYCLES; err_index=0; go=0; no further transfers.
- rst pulsed while XFER is active on entry 1 -> go=0 the next cycle; all outputs at reset values; cfg_start again -> pass restarts from index 0.
- cfg_start pulsed again while busy -> no effect; the pass completes normally with one cfg_done.
- Table full with no end marker (TBL_AW=2, four writes) -> exactly four transfers, then cfg_done=1, with no index wrap-around.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_cfg_pkg                                                          |
// | Shared states, table markers and ms-prescaler helper.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_PWRUP  = 4'd1,
    ST_FETCH  = 4'd2,
    ST_DECODE = 4'd3,
    ST_REQ    = 4'd4,
    ST_XFER   = 4'd5,
    ST_GAP    = 4'd6,
    ST_DELAY  = 4'd7,
    ST_DONE   = 4'd8,
    ST_ERR    = 4'd9
  } state_t;

  localparam logic [15:0] c_mark_delay = 16'hFFFF;
  localparam logic [15:0] c_mark_end   = 16'hFFFE;
  localparam int unsigned c_ms_div     = 1000;

  function automatic int unsigned ms_cycles(input int unsigned clk_freq);
    return clk_freq / c_ms_div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_delay_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfg_delay_timer                                                      |
// | Millisecond prescaler plus 8-bit ms down-counter with load/expired.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cfg_delay_timer #(
  parameter int unsigned MS_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_ms,
  output logic       expired
);

  localparam int c_pre_w = $clog2(MS_CYCLES + 1);
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(MS_CYCLES - 1);

  logic [c_pre_w-1:0] r_pre;
  logic [7:0]         r_ms;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (load) begin
      r_pre <= '0;
      r_ms  <= load_ms;
    end else if (r_ms != 8'd0) begin
      if (r_pre == c_pre_last) begin
        r_pre <= '0;
        r_ms  <= r_ms - 8'd1;
      end else begin
        r_pre <= r_pre + c_pre_w'(1);
      end
    end
  end

  // A zero load reads as expired on the very next cycle.
  assign expired = (r_ms == 8'd0);

endmodule
`default_nettype wire

// File: rtl/i2c_config_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_config_sequencer                                                 |
// | Walks an external register table and issues I2C writes via go.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 25000000,
  parameter logic [7:0]  DEV_ADDR       = 8'h78,
  parameter int unsigned TBL_AW         = 8,
  parameter int unsigned PWRUP_MS       = 20,
  parameter int unsigned GAP_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic              sys_clock,
  input  logic              rst,
  input  logic              cfg_start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic [7:0]        I2C_addr,
  output logic [23:0]       I2C_WDATA,
  output logic              go,
  input  logic              trans_finished,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [TBL_AW-1:0] err_index
);

  localparam int unsigned c_cnt_max = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int c_cnt_w = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic [TBL_AW-1:0]  c_last_idx = '1;
  localparam logic [7:0]         c_pwrup_ms = 8'(PWRUP_MS);

  state_t              r_state, w_next;
  logic                r_start_d, w_start_edge;
  logic                r_tf_meta, r_tf_sync;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [TBL_AW-1:0]   r_index, r_err_idx;
  logic [23:0]         r_wdata;
  logic [7:0]          r_addr;
  logic                r_go, r_busy, r_done, r_err;
  logic                w_timer_load, w_expired;
  logic [7:0]          w_timer_ms;
  logic                w_idx_clr, w_idx_inc, w_latch, w_set_err;

  assign w_start_edge = cfg_start & ~r_start_d;

  cfg_delay_timer #(
    .MS_CYCLES (ms_cycles(CLK_FREQ))
  ) u_timer (
    .clk     (sys_clock),
    .rst     (rst),
    .load    (w_timer_load),
    .load_ms (w_timer_ms),
    .expired (w_expired)
  );

  always_ff @(posedge sys_clock) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_timer_load = 1'b0;
    w_timer_ms   = tbl_data[7:0];
    w_idx_clr    = 1'b0;
    w_idx_inc    = 1'b0;
    w_latch      = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start_edge) begin
        w_next       = ST_PWRUP;
        w_idx_clr    = 1'b1;
        w_timer_load = 1'b1;
        w_timer_ms   = c_pwrup_ms;
      end
      ST_PWRUP: if (w_expired) w_next = ST_FETCH;
      ST_FETCH: w_next = ST_DECODE;
      ST_DECODE: begin
        if (tbl_data[23:8] == c_mark_delay) begin
          w_next       = ST_DELAY;
          w_timer_load = 1'b1;
        end else if (tbl_data[23:8] == c_mark_end) begin
          w_next = ST_DONE;
        end else begin
          w_latch = 1'b1;
          w_next  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!r_tf_sync) w_next = ST_XFER;
        else if (r_cnt == c_tmo_last) begin
          w_next    = ST_ERR;
          w_set_err = 1'b1;
        end
      end
      ST_XFER: begin
        if (r_tf_sync) w_next = ST_GAP;
        else if (r_cnt == c_tmo_last) begin
          w_next    = ST_ERR;
          w_set_err = 1'b1;
        end
      end
      ST_GAP: if (r_cnt == c_gap_last) begin
        if (r_index == c_last_idx) w_next = ST_DONE;
        else begin
          w_idx_inc = 1'b1;
          w_next    = ST_FETCH;
        end
      end
      ST_DELAY: if (w_expired) begin
        if (r_index == c_last_idx) w_next = ST_DONE;
        else begin
          w_idx_inc = 1'b1;
          w_next    = ST_FETCH;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // go/busy are registered from the next state so they track the FSM without lag.
  always_ff @(posedge sys_clock) begin
    if (rst) begin
      r_start_d <= 1'b0;
      r_tf_meta <= 1'b1;
      r_tf_sync <= 1'b1;
      r_cnt     <= '0;
      r_index   <= '0;
      r_err_idx <= '0;
      r_wdata   <= '0;
      r_addr    <= DEV_ADDR;
      r_go      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_start_d <= cfg_start;
      r_tf_meta <= trans_finished;
      r_tf_sync <= r_tf_meta;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state inside {ST_REQ, ST_XFER, ST_GAP}) r_cnt <= r_cnt + c_cnt_w'(1);
      if (w_idx_clr)      r_index <= '0;
      else if (w_idx_inc) r_index <= r_index + TBL_AW'(1);
      if (w_latch) begin
        r_wdata <= tbl_data;
        r_addr  <= DEV_ADDR;
      end
      r_go   <= (w_next == ST_REQ) || (w_next == ST_XFER);
      r_busy <= (w_next != ST_IDLE);
      if (w_idx_clr) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        if (r_state == ST_DONE) r_done <= 1'b1;
        if (w_set_err) begin
          r_err     <= 1'b1;
          r_err_idx <= r_index;
        end
      end
    end
  end

  assign tbl_addr  = r_index;
  assign I2C_addr  = r_addr;
  assign I2C_WDATA = r_wdata;
  assign go        = r_go;
  assign busy      = r_busy;
  assign cfg_done  = r_done;
  assign cfg_err   = r_err;
  assign err_index = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_i2c_config_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2c_config_sequencer                                              |
// | Directed scenarios with a behavioural I2C controller and table ROM.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_i2c_config_sequencer;

  localparam int unsigned CLK_FREQ = 100000;  // 100 cycles per ms
  localparam int unsigned TIMEOUT  = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [1:0]  tbl_addr;
  logic [23:0] tbl_data = '0;
  logic [7:0]  I2C_addr;
  logic [23:0] I2C_WDATA;
  logic        go;
  logic        trans_finished = 1'b1;
  logic        busy, cfg_done, cfg_err;
  logic [1:0]  err_index;

  logic [23:0] rom [4];
  logic        ctl_dead = 1'b0;
  int          ctl_cnt = 0;
  int          cyc = 0;

  int          n_vec = 0;
  int          n_err = 0;

  logic        go_q = 1'b0, done_q = 1'b0;
  logic [23:0] wd_q = '0;
  int          xfer_cnt = 0, done_rises = 0, unstable = 0, last_fall = 0;
  logic [23:0] xfer_data [64];
  int          rise_cyc [64];

  i2c_config_sequencer #(
    .CLK_FREQ(CLK_FREQ), .DEV_ADDR(8'h78), .TBL_AW(2), .PWRUP_MS(20),
    .GAP_CYCLES(64), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .sys_clock(clk), .rst(rst), .cfg_start(cfg_start), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .I2C_addr(I2C_addr), .I2C_WDATA(I2C_WDATA), .go(go),
    .trans_finished(trans_finished), .busy(busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .err_index(err_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    tbl_data <= rom[tbl_addr];
  end

  // Controller: finished drops 3 cycles after go rises, returns 100 cycles later.
  always @(posedge clk) begin
    if (!go) begin
      ctl_cnt        <= 0;
      trans_finished <= 1'b1;
    end else begin
      ctl_cnt <= ctl_cnt + 1;
      if (!ctl_dead) begin
        if (ctl_cnt == 2)        trans_finished <= 1'b0;
        else if (ctl_cnt == 102) trans_finished <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    go_q   <= go;
    wd_q   <= I2C_WDATA;
    done_q <= cfg_done;
    if (go && !go_q) begin
      xfer_data[xfer_cnt % 64] <= I2C_WDATA;
      rise_cyc[xfer_cnt % 64]  <= cyc;
      xfer_cnt <= xfer_cnt + 1;
    end
    if (!go && go_q) last_fall <= cyc;
    if (go && go_q && (I2C_WDATA != wd_q)) unstable <= unstable + 1;
    if (cfg_done && !done_q) done_rises <= done_rises + 1;
  end

  task automatic load_rom(input logic [23:0] a, b, c, d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic pulse_start(output int start_cyc);
    @(negedge clk);
    cfg_start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle_wait: busy=%b after %0d cycles, want 0", tag, busy, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(4);
    rst = 1'b0;
    idle(2);
    n_vec += 8;
    if (go !== 1'b0)            begin n_err++; $display("FAIL reset_go: got %b want 0", go); end
    if (busy !== 1'b0)          begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (cfg_done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b want 0", cfg_done); end
    if (cfg_err !== 1'b0)       begin n_err++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    if (err_index !== 2'd0)     begin n_err++; $display("FAIL reset_err_index: got %0d want 0", err_index); end
    if (tbl_addr !== 2'd0)      begin n_err++; $display("FAIL reset_tbl_addr: got %0d want 0", tbl_addr); end
    if (I2C_WDATA !== 24'h0)    begin n_err++; $display("FAIL reset_wdata: got %h want 000000", I2C_WDATA); end
    if (I2C_addr !== 8'h78)     begin n_err++; $display("FAIL reset_addr: got %h want 78", I2C_addr); end
  endtask

  task automatic test_basic;
    int s, b0, bu, bd;
    load_rom(24'h300882, 24'h310303, 24'hFFFE00, 24'h000000);
    b0 = xfer_cnt; bu = unstable; bd = done_rises;
    pulse_start(s);
    wait_idle(8000, "basic");
    n_vec += 9;
    if (xfer_cnt - b0 != 2) begin n_err++; $display("FAIL basic_count: got %0d want 2", xfer_cnt - b0); end
    if (xfer_data[b0 % 64] !== 24'h300882) begin n_err++; $display("FAIL basic_wdata0: got %h want 300882", xfer_data[b0 % 64]); end
    if (xfer_data[(b0+1) % 64] !== 24'h310303) begin n_err++; $display("FAIL basic_wdata1: got %h want 310303", xfer_data[(b0+1) % 64]); end
    if (rise_cyc[b0 % 64] - s < 2000 || rise_cyc[b0 % 64] - s > 2010)
      begin n_err++; $display("FAIL basic_pwrup: first go after %0d cycles, want 2000..2010", rise_cyc[b0 % 64] - s); end
    if (cfg_done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", cfg_done); end
    if (cfg_err !== 1'b0)  begin n_err++; $display("FAIL basic_err: got %b want 0", cfg_err); end
    if (unstable != bu)    begin n_err++; $display("FAIL basic_stable: %0d wdata changes during go, want 0", unstable - bu); end
    if (done_rises - bd != 1) begin n_err++; $display("FAIL basic_done_rises: got %0d want 1", done_rises - bd); end
    if (tbl_addr !== 2'd2) begin n_err++; $display("FAIL basic_end_index: got %0d want 2", tbl_addr); end
  endtask

  task automatic test_delay;
    int s, b0;
    load_rom(24'hFFFF05, 24'h430030, 24'hFFFE00, 24'h000000);
    b0 = xfer_cnt;
    pulse_start(s);
    wait_idle(8000, "delay");
    n_vec += 4;
    if (xfer_cnt - b0 != 1) begin n_err++; $display("FAIL delay_count: got %0d want 1", xfer_cnt - b0); end
    if (xfer_data[b0 % 64] !== 24'h430030) begin n_err++; $display("FAIL delay_wdata: got %h want 430030", xfer_data[b0 % 64]); end
    if (rise_cyc[b0 % 64] - s < 2500 || rise_cyc[b0 % 64] - s > 2515)
      begin n_err++; $display("FAIL delay_wait: first go after %0d cycles, want 2500..2515", rise_cyc[b0 % 64] - s); end
    if (cfg_done !== 1'b1) begin n_err++; $display("FAIL delay_done: got %b want 1", cfg_done); end
  endtask

  task automatic test_timeout;
    int s, b0;
    load_rom(24'h300882, 24'h310303, 24'hFFFE00, 24'h000000);
    ctl_dead = 1'b1;
    b0 = xfer_cnt;
    pulse_start(s);
    wait_idle(8000, "timeout");
    n_vec += 6;
    if (cfg_err !== 1'b1)   begin n_err++; $display("FAIL timeout_err: got %b want 1", cfg_err); end
    if (err_index !== 2'd0) begin n_err++; $display("FAIL timeout_index: got %0d want 0", err_index); end
    if (go !== 1'b0)        begin n_err++; $display("FAIL timeout_go: got %b want 0", go); end
    if (cfg_done !== 1'b0)  begin n_err++; $display("FAIL timeout_done: got %b want 0", cfg_done); end
    if (last_fall - rise_cyc[b0 % 64] != TIMEOUT)
      begin n_err++; $display("FAIL timeout_len: go high %0d cycles, want %0d", last_fall - rise_cyc[b0 % 64], TIMEOUT); end
    idle(600);
    if (xfer_cnt - b0 != 1) begin n_err++; $display("FAIL timeout_count: got %0d want 1", xfer_cnt - b0); end
    ctl_dead = 1'b0;
  endtask

  task automatic test_reset_mid;
    int s, b0, n;
    load_rom(24'h300882, 24'h310303, 24'hFFFE00, 24'h000000);
    b0 = xfer_cnt;
    pulse_start(s);
    n = 0;
    while (xfer_cnt - b0 < 2 && n < 6000) begin @(negedge clk); n++; end
    idle(20);
    n_vec += 3;
    if (go !== 1'b1 || trans_finished !== 1'b0)
      begin n_err++; $display("FAIL mid_in_xfer: go=%b finished=%b, want 1/0", go, trans_finished); end
    rst = 1'b1;
    @(negedge clk);
    if (go !== 1'b0)   begin n_err++; $display("FAIL mid_go_drop: got %b want 0", go); end
    rst = 1'b0;
    idle(100);
    if (busy !== 1'b0 || cfg_done !== 1'b0 || tbl_addr !== 2'd0 || I2C_WDATA !== 24'h0 || I2C_addr !== 8'h78)
      begin n_err++; $display("FAIL mid_reset_vals: busy=%b done=%b addr=%0d wdata=%h i2c=%h", busy, cfg_done, tbl_addr, I2C_WDATA, I2C_addr); end
    b0 = xfer_cnt;
    pulse_start(s);
    n_vec += 4;
    if (busy !== 1'b1 || tbl_addr !== 2'd0)
      begin n_err++; $display("FAIL mid_restart: busy=%b addr=%0d, want 1/0", busy, tbl_addr); end
    wait_idle(8000, "mid");
    if (xfer_cnt - b0 != 2) begin n_err++; $display("FAIL mid_count: got %0d want 2", xfer_cnt - b0); end
    if (xfer_data[b0 % 64] !== 24'h300882) begin n_err++; $display("FAIL mid_wdata0: got %h want 300882", xfer_data[b0 % 64]); end
    if (cfg_done !== 1'b1) begin n_err++; $display("FAIL mid_done: got %b want 1", cfg_done); end
  endtask

  task automatic test_busy_restart;
    int s, s2, b0, bd, n;
    load_rom(24'h300882, 24'h310303, 24'hFFFE00, 24'h000000);
    b0 = xfer_cnt; bd = done_rises;
    pulse_start(s);
    idle(500);
    pulse_start(s2);
    n = 0;
    while (xfer_cnt - b0 < 1 && n < 6000) begin @(negedge clk); n++; end
    idle(10);
    pulse_start(s2);
    wait_idle(8000, "busy");
    n_vec += 4;
    if (xfer_cnt - b0 != 2) begin n_err++; $display("FAIL busy_count: got %0d want 2", xfer_cnt - b0); end
    if (done_rises - bd != 1) begin n_err++; $display("FAIL busy_done_rises: got %0d want 1", done_rises - bd); end
    if (rise_cyc[b0 % 64] - s < 2000 || rise_cyc[b0 % 64] - s > 2010)
      begin n_err++; $display("FAIL busy_pwrup: first go after %0d cycles, want 2000..2010", rise_cyc[b0 % 64] - s); end
    if (xfer_data[(b0+1) % 64] !== 24'h310303) begin n_err++; $display("FAIL busy_wdata1: got %h want 310303", xfer_data[(b0+1) % 64]); end
  endtask

  task automatic test_full_table;
    int s, b0;
    load_rom(24'h110011, 24'h220022, 24'h330033, 24'h440044);
    b0 = xfer_cnt;
    pulse_start(s);
    wait_idle(8000, "full");
    n_vec += 7;
    if (xfer_data[b0 % 64] !== 24'h110011) begin n_err++; $display("FAIL full_wdata0: got %h want 110011", xfer_data[b0 % 64]); end
    if (xfer_data[(b0+1) % 64] !== 24'h220022) begin n_err++; $display("FAIL full_wdata1: got %h want 220022", xfer_data[(b0+1) % 64]); end
    if (xfer_data[(b0+2) % 64] !== 24'h330033) begin n_err++; $display("FAIL full_wdata2: got %h want 330033", xfer_data[(b0+2) % 64]); end
    if (xfer_data[(b0+3) % 64] !== 24'h440044) begin n_err++; $display("FAIL full_wdata3: got %h want 440044", xfer_data[(b0+3) % 64]); end
    if (cfg_done !== 1'b1) begin n_err++; $display("FAIL full_done: got %b want 1", cfg_done); end
    if (tbl_addr !== 2'd3) begin n_err++; $display("FAIL full_no_wrap: index %0d want 3", tbl_addr); end
    idle(300);
    if (xfer_cnt - b0 != 4) begin n_err++; $display("FAIL full_count: got %0d want 4", xfer_cnt - b0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_delay;
    test_timeout;
    test_reset_mid;
    test_busy_restart;
    test_full_table;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
